// File: rtl/blink_timer.sv
// blink_timer: LED blinker driven by a base-tick prescaler and a one-hot rate select.
// Optional BLINK_TIMER_PHASE_RESTART_EN: a rate change restarts the current interval.
module blink_timer #(
  parameter int unsigned CLK_PER_TICK = 6250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [9:0] rate_sel,
  output logic       led,
  output logic       toggle,
  output logic       tick
);

  localparam int unsigned PW = $clog2(CLK_PER_TICK);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_TICK - 1);

  typedef enum logic [9:0] {
    RATE_8S    = 10'h100,
    RATE_4S    = 10'h080,
    RATE_2S    = 10'h040,
    RATE_1S    = 10'h020,
    RATE_500MS = 10'h010,
    RATE_250MS = 10'h008,
    RATE_125MS = 10'h004
  } rate_e;

  rate_e         rate_q;
  logic [PW-1:0] presc;
  logic [5:0]    period;
  logic [5:0]    n_m1;
  logic [6:0]    hot;
  logic          rate_ok;
  logic          wrap;
  logic          restart;
  logic          tick_q;
  logic          toggle_q;

  // Exactly one of bits 2..8 set, everything else clear.
  assign hot     = rate_sel[8:2];
  assign rate_ok = (rate_sel[1:0] == 2'b00) && !rate_sel[9] &&
                   (hot != '0) && ((hot & (hot - 7'd1)) == '0);

`ifdef BLINK_TIMER_PHASE_RESTART_EN
  assign restart = rate_ok && (rate_sel != rate_q);
`else
  assign restart = 1'b0;
`endif

  assign wrap = enable && (presc == PRE_MAX);

  always_comb begin
    n_m1 = 6'd7;
    case (rate_q)
      RATE_8S:    n_m1 = 6'd63;
      RATE_4S:    n_m1 = 6'd31;
      RATE_2S:    n_m1 = 6'd15;
      RATE_1S:    n_m1 = 6'd7;
      RATE_500MS: n_m1 = 6'd3;
      RATE_250MS: n_m1 = 6'd1;
      RATE_125MS: n_m1 = 6'd0;
      default:    n_m1 = 6'd7;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rate_q   <= RATE_1S;
      presc    <= '0;
      period   <= '0;
      led      <= 1'b0;
      tick_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      tick_q   <= wrap;
      toggle_q <= 1'b0;
      if (rate_ok) begin
        rate_q <= rate_e'(rate_sel);
      end
      if (restart) begin
        presc  <= '0;
        period <= '0;
      end else if (enable) begin
        presc <= wrap ? '0 : presc + PW'(1);
        // >= rather than == so a switch to a shorter interval toggles at the next wrap.
        if (wrap) begin
          if (period >= n_m1) begin
            period   <= '0;
            led      <= ~led;
            toggle_q <= 1'b1;
          end else begin
            period <= period + 6'd1;
          end
        end
      end
    end
  end

  // Strobes are forced low while frozen.
  assign tick   = tick_q & enable;
  assign toggle = toggle_q & enable;

endmodule

// File: tb/tb_blink_timer.sv
// Self-checking bench for blink_timer (CLK_PER_TICK=4): expected toggle edges are queued
// as stimulus is applied and matched against observed toggle strobes.
module tb_blink_timer;

  localparam int unsigned T = 4;
`ifdef BLINK_TIMER_PHASE_RESTART_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] rate_sel = '0;
  logic       led;
  logic       toggle;
  logic       tick;

  blink_timer #(.CLK_PER_TICK(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .rate_sel (rate_sel),
    .led      (led),
    .toggle   (toggle),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic led;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tick_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_toggle(input int c, input logic l);
    exp_t e;
    e.cyc = c;
    e.led = l;
    exp_q.push_back(e);
  endtask

  // Leaves the caller at the falling edge following rising edge number c.
  task automatic run_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    cyc++;
    #1;
    if (tick) tick_cnt++;
    if (toggle) begin
      if (exp_q.size() == 0) begin
        check("toggle_unexpected", cyc, -1);
      end else begin
        e = exp_q.pop_front();
        check("toggle_cycle", cyc, e.cyc);
        check("toggle_led", int'(led), int'(e.led));
      end
    end
  end

  initial begin
    int b, p, q, s, t8, u, w, r2;

    rst      = 1'b0;
    enable   = 1'b1;
    rate_sel = 10'h004;
    run_to(3);
    check("rst_led", int'(led), 0);
    check("rst_toggle", int'(toggle), 0);
    check("rst_tick", int'(tick), 0);

    // 1/8 s: toggle every tick
    b   = cyc + R;
    rst = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) expect_toggle(b + 4 * int'(i), (i % 2) == 1);
    tick_cnt = 0;
    run_to(b + 16);
    check("tick_125ms", tick_cnt, 4);

    // 1 s: toggle every 32 cycles
    rate_sel = 10'h020;
    expect_toggle(b + 48 + R, 1'b1);
    expect_toggle(b + 80 + R, 1'b0);
    tick_cnt = 0;
    run_to(b + 80 + R);
    check("tick_1s", tick_cnt, 16);

    // Invalid codes must not disturb the 1 s cadence
    p = cyc;
    rate_sel = 10'h000;
    expect_toggle(p + 32, 1'b1);
    expect_toggle(p + 64, 1'b0);
    run_to(p + 5);  rate_sel = 10'h030;
    run_to(p + 10); rate_sel = 10'h200;
    run_to(p + 15); rate_sel = 10'h001;
    run_to(p + 20); rate_sel = 10'h020;
    run_to(p + 64);

    // Freeze for 10 cycles mid-interval
    q = cyc;
    expect_toggle(q + 42, 1'b1);
    run_to(q + 10);
    enable   = 1'b0;
    tick_cnt = 0;
    run_to(q + 20);
    check("freeze_tick", tick_cnt, 0);
    check("freeze_led", int'(led), 0);
    enable = 1'b1;
    run_to(q + 42);

    // 8 s: toggle every 256 cycles
    s        = cyc;
    rate_sel = 10'h100;
    t8       = s + 256 + R;
    expect_toggle(t8, 1'b0);
    tick_cnt = 0;
    run_to(t8);
    check("tick_8s", tick_cnt, 64);

    // Period counter at 40, prescaler mid-tick: switch to 1/4 s
    u = t8 + 162;
    run_to(u);
    rate_sel = 10'h008;
    expect_toggle(u + 2 + 7 * R, 1'b1);
    expect_toggle(u + 10 + 7 * R, 1'b0);
    expect_toggle(u + 18 + 7 * R, 1'b1);
    w = u + 18 + 7 * R;

    // Asynchronous reset mid-interval with led high
    run_to(w + 3);
    check("pending_before_rst", exp_q.size(), 0);
    check("led_before_rst", int'(led), 1);
    rate_sel = 10'h000;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_led", int'(led), 0);
    check("async_rst_toggle", int'(toggle), 0);
    check("async_rst_tick", int'(tick), 0);
    run_to(w + 6);
    r2  = cyc;
    rst = 1'b1;
    expect_toggle(r2 + 32, 1'b1);
    tick_cnt = 0;
    run_to(r2 + 34);
    check("tick_after_rst", tick_cnt, 8);
    check("pending_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/blink_timer.md
BLINK_TIMER -- requirements
Module: blink_timer

Interface
REQ-001 SHALL have parameter CLK_PER_TICK, default 6250000, giving clock cycles per base tick (1/8 s at 50 MHz); legal range 2..2^24.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port enable, input, 1 bit: run when high; freeze when low.
REQ-005 SHALL have port rate_sel, input, 10 bits: one-hot rate code from the rate shifter; bit8=8 s, bit7=4 s, bit6=2 s, bit5=1 s, bit4=1/2 s, bit3=1/4 s, bit2=1/8 s.
REQ-006 SHALL have port led, output, 1 bit: blink output, registered.
REQ-007 SHALL have port toggle, output, 1 bit: one-cycle strobe marking each led transition.
REQ-008 SHALL have port tick, output, 1 bit: one-cycle strobe marking each base tick.

Function
REQ-009 SHALL accept rate_sel only when exactly one of bits 2..8 is set and bits 0, 1 and 9 are clear.
REQ-010 SHALL register each accepted rate_sel into rate_q; an invalid code (zero, multi-hot, bits 0/1/9) SHALL leave rate_q unchanged.
REQ-011 SHALL decode rate_q to a toggle interval N in ticks: 8 s=64, 4 s=32, 2 s=16, 1 s=8, 1/2 s=4, 1/4 s=2, 1/8 s=1.
REQ-012 SHALL run a prescaler counting 0..CLK_PER_TICK-1 while enable=1, wrapping to 0 at CLK_PER_TICK-1.
REQ-013 SHALL raise tick for exactly one cycle after each clock edge on which the prescaler wraps.
REQ-014 SHALL run a 6-bit period counter that advances by one on each prescaler wrap.
REQ-015 On a prescaler wrap with period counter >= N-1: SHALL clear the period counter, invert led, and raise toggle for exactly one cycle, all on the same edge.
REQ-016 With enable=0: prescaler, period counter and led SHALL hold; tick and toggle SHALL be 0; rate_q SHALL still update per REQ-010.
REQ-017 Raising enable SHALL resume counting from the held counter values, with no extra tick or toggle.
REQ-018 The period counter SHALL never exceed 63 or wrap past N-1.
REQ-019 A rate change on the same edge as a wrap SHALL use the old N for that edge.

Reset
REQ-020 While rst=0: rate_q SHALL be 1 s (bit5), prescaler=0, period counter=0, led=0, toggle=0, tick=0, independent of clk.
REQ-021 Reset asserted mid-interval SHALL abort the interval with no toggle; counting SHALL restart from 0 on the first rising clk edge after rst deasserts.

Configuration
REQ-022 With macro BLINK_TIMER_PHASE_RESTART_EN defined: any rate_q update to a different value SHALL clear prescaler and period counter on that edge, so the first toggle at the new rate occurs N*CLK_PER_TICK cycles later; led SHALL hold.
REQ-023 Without BLINK_TIMER_PHASE_RESTART_EN: counters SHALL continue across a rate change, and the >= compare of REQ-015 SHALL handle a shorter N.

Verification (CLK_PER_TICK=4)
REQ-024 Reset release, enable=1, rate_sel=0x004 (1/8 s) -> tick and toggle every 4 cycles; led=1 after 4 cycles, 0 after 8.
REQ-025 rate_sel=0x020 (1 s) -> toggle every 32 cycles; rate_sel=0x100 (8 s) -> toggle every 256 cycles; tick every 4 cycles in both cases.
REQ-026 At 1 s rate, drive rate_sel=0x000 then 0x030 -> toggle spacing stays 32 cycles.
REQ-027 enable=0 for 10 cycles mid-interval -> led, tick and toggle frozen; the next toggle is delayed by exactly 10 cycles.
REQ-028 At 8 s rate with period counter=40, switch to 0x008 (1/4 s) -> with the macro, next toggle 8 cycles later; without it, toggle at the next wrap and every 8 cycles after.
REQ-029 rst pulsed low mid-interval with led=1 -> led=0, toggle=0 immediately; first toggle 32 cycles after release at the default 1 s rate.
